mixcolumns_seq: RTL and testbench

Column-serial AES forward MixColumns engine for the encryption datapath. It is the forward counterpart of the combinational inverse MixColumns used on the decrypt side. It accepts one 128-bit state over a valid/ready handshake, transforms one 32-bit column per cycle, and presents the 128-bit result over a second valid/ready handshake. It trades the fully parallel GF(2^8) multiplier array for one shared column datapath.

---
 rtl/mixcolumns_seq_pkg.sv | 23 ++
 rtl/mixcolumns_seq_if.sv | 40 ++++
 rtl/mixcolumns_seq_column.sv | 62 ++++++
 rtl/mixcolumns_seq.sv | 108 ++++++++++
 tb/tb_mixcolumns_seq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mixcolumns_seq_pkg.sv
// Shared AES definitions: byte/column/state types, the xtime helper and the
// FSM state encoding of the column-serial MixColumns engine.
package aes_pkg;

  localparam logic [7:0] RED_POLY_DEFAULT = 8'h1B;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } mixcol_state_e;

  // Multiply by x in GF(2^8), reducing with the supplied polynomial tail.
  function automatic aes_byte_t xtime(input aes_byte_t b,
                                      input aes_byte_t poly = RED_POLY_DEFAULT);
    return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/mixcolumns_seq_if.sv
// State-in / state-out handshake bundle of mixcolumns_seq.
// The inv select exists only when MIXCOL_INV_EN is defined.
interface mixcolumns_seq_if;
  import aes_pkg::*;

  aes_state_t in;
  logic       in_valid;
  logic       in_ready;
  aes_state_t out;
  logic       out_valid;
  logic       out_ready;
`ifdef MIXCOL_INV_EN
  logic       inv;
`endif

  modport master (
`ifdef MIXCOL_INV_EN
    output inv,
`endif
    output in,
    output in_valid,
    input  in_ready,
    input  out,
    input  out_valid,
    output out_ready
  );

  modport slave (
`ifdef MIXCOL_INV_EN
    input  inv,
`endif
    input  in,
    input  in_valid,
    output in_ready,
    output out,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/mixcolumns_seq_column.sv
// Single-column MixColumns datapath (combinational). With MIXCOL_INV_EN the
// inverse matrix is added and selected by inv_i.
module mixcol_column
  import aes_pkg::*;
#(
  parameter aes_byte_t RED_POLY = RED_POLY_DEFAULT
) (
  input  aes_col_t col_i,
`ifdef MIXCOL_INV_EN
  input  logic     inv_i,
`endif
  output aes_col_t col_o
);

  aes_byte_t a  [4];
  aes_byte_t x2 [4];
  aes_byte_t x3 [4];
  aes_col_t  fwd;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k]  = col_i[31-8*k -: 8];
      x2[k] = xtime(a[k], RED_POLY);
      x3[k] = x2[k] ^ a[k];
    end
    fwd = {x2[0] ^ x3[1] ^ a[2]  ^ a[3],
           a[0]  ^ x2[1] ^ x3[2] ^ a[3],
           a[0]  ^ a[1]  ^ x2[2] ^ x3[3],
           x3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
  end

`ifdef MIXCOL_INV_EN
  aes_byte_t x4  [4];
  aes_byte_t x8  [4];
  aes_byte_t m9  [4];
  aes_byte_t m11 [4];
  aes_byte_t m13 [4];
  aes_byte_t m14 [4];
  aes_col_t  rev;

  // 9/11/13/14 multiples are sums of the 1/2/4/8 xtime chain.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      x4[k]  = xtime(x2[k], RED_POLY);
      x8[k]  = xtime(x4[k], RED_POLY);
      m9[k]  = x8[k] ^ a[k];
      m11[k] = x8[k] ^ x2[k] ^ a[k];
      m13[k] = x8[k] ^ x4[k] ^ a[k];
      m14[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    rev = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
           m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
           m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
           m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  end

  assign col_o = inv_i ? rev : fwd;
`else
  assign col_o = fwd;
`endif

endmodule

// File: rtl/mixcolumns_seq.sv
// Column-serial AES MixColumns engine: accepts a state, transforms one column
// per cycle through a shared datapath. Optional inverse via MIXCOL_INV_EN.
module mixcolumns_seq
  import aes_pkg::*;
#(
  parameter aes_byte_t RED_POLY = RED_POLY_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  mixcolumns_seq_if.slave bus
);

  mixcol_state_e state_q, state_d;
  logic [1:0]    col_cnt_q, col_cnt_d;
  aes_state_t    data_q, data_d;
  aes_state_t    out_q, out_d;
  aes_col_t      col_in, col_out;
  logic          accept;
  logic          last_col;
  logic          in_ready;
  logic          out_valid;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last_col = (state_q == CALC) && (col_cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (last_col)      state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_q;

  always_comb begin
    unique case (col_cnt_q)
      2'd0:    col_in = data_q[127:96];
      2'd1:    col_in = data_q[95:64];
      2'd2:    col_in = data_q[63:32];
      default: col_in = data_q[31:0];
    endcase
  end

`ifdef MIXCOL_INV_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (accept) inv_q <= bus.inv;
  end

  mixcol_column #(.RED_POLY(RED_POLY)) u_col (
    .col_i (col_in),
    .inv_i (inv_q),
    .col_o (col_out)
  );
`else
  mixcol_column #(.RED_POLY(RED_POLY)) u_col (
    .col_i (col_in),
    .col_o (col_out)
  );
`endif

  // Column counter naturally returns to 0 on the column-3 write.
  always_comb begin
    data_d    = data_q;
    out_d     = out_q;
    col_cnt_d = col_cnt_q;
    if (accept) begin
      data_d    = bus.in;
      col_cnt_d = 2'd0;
    end else if (state_q == CALC) begin
      col_cnt_d = col_cnt_q + 2'd1;
      unique case (col_cnt_q)
        2'd0:    out_d[127:96] = col_out;
        2'd1:    out_d[95:64]  = col_out;
        2'd2:    out_d[63:32]  = col_out;
        default: out_d[31:0]   = col_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (!rst_n) begin
      col_cnt_q <= 2'd0;
      out_q     <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Self-checking bench for mixcolumns_seq: fixed vectors, random blocks against a
// GF(2^8) matrix model, backpressure, mid-block reset and back-to-back streaming.
module tb_mixcolumns_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mixcolumns_seq_if bus();

  mixcolumns_seq #(.RED_POLY(8'h1B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  logic inv_sel = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef MIXCOL_INV_EN
  assign bus.inv = inv_sel;
`endif

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      base[0] = 8'd14; base[1] = 8'd11; base[2] = 8'd13; base[3] = 8'd9;
    end else begin
      base[0] = 8'd2;  base[1] = 8'd3;  base[2] = 8'd1;  base[3] = 8'd1;
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(base[(k - r + 4) % 4], s[127-32*c-8*k -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    nvec++;
    nfail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input string nm);
    int acc;
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
    if (!bus.in_ready) begin timeout({nm, " in_ready"}); return; end
    bus.in = din;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    acc = cyc;
    t = 0;
    while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
    if (!bus.out_valid) begin timeout({nm, " out_valid"}); return; end
    chk({nm, " latency"}, 128'(cyc - acc), 128'd4);
    chk({nm, " data"}, bus.out, exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, " release"}, {126'd0, bus.out_valid, bus.in_ready}, 128'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL global: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] v;
    logic [127:0] held;
    logic [127:0] q[$];
    int t;
    int got;
    int prev;

    tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    tbl[1] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
    tbl[2] = '{128'h00000000_00000000_00000000_00000000, 128'h00000000_00000000_00000000_00000000};
    tbl[3] = '{128'h01010101_c6c6c6c6_ffffffff_01010101, 128'h01010101_c6c6c6c6_ffffffff_01010101};

    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ctrl", {126'd0, bus.out_valid, bus.in_ready}, 128'b01);
    chk("reset out", bus.out, 128'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_block(tbl[i].din, tbl[i].exp, $sformatf("table%0d", i));

    for (int i = 0; i < 6; i++) begin
      v = rnd128();
      run_block(v, model(v, 1'b0), $sformatf("random%0d", i));
    end

    // Backpressure: output held while out_ready is low, in_valid ignored.
    @(negedge clk);
    v = rnd128();
    bus.in = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
    if (!bus.out_valid) timeout("bp out_valid");
    held = bus.out;
    chk("bp data", held, model(v, 1'b0));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in = rnd128();
      @(negedge clk);
      chk("bp stable", bus.out, held);
      chk("bp ctrl", {126'd0, bus.out_valid, bus.in_ready}, 128'b10);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp release", {126'd0, bus.out_valid, bus.in_ready}, 128'b01);
    @(negedge clk);
    chk("bp single", {126'd0, bus.out_valid, bus.in_ready}, 128'b01);

    // Reset during the second CALC cycle.
    bus.in = rnd128();
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst ctrl", {126'd0, bus.out_valid, bus.in_ready}, 128'b01);
    chk("midrst out", bus.out, 128'h0);
    rst_n = 1'b1;
    v = rnd128();
    run_block(v, model(v, 1'b0), "after reset");

    // Back-to-back streaming with in_valid and out_ready held high.
    @(negedge clk);
    got = 0;
    prev = -1;
    t = 0;
    bus.in = rnd128();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 5 && t < 200) begin
      if (bus.out_valid) begin
        if (q.size() == 0) timeout("b2b unexpected output");
        else chk("b2b data", bus.out, q.pop_front());
        got++;
      end
      if (bus.in_ready && got < 5) begin
        q.push_back(model(bus.in, 1'b0));
        if (prev >= 0) chk("b2b spacing", 128'(cyc - prev), 128'd6);
        prev = cyc;
      end else begin
        bus.in = rnd128();
      end
      if (got >= 5) bus.in_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    if (got < 5) timeout("b2b results");
    q.delete();

`ifdef MIXCOL_INV_EN
    inv_sel = 1'b1;
    run_block(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
              128'hdb135345_f20a225c_01010101_c6c6c6c6, "inverse vec");
    for (int i = 0; i < 3; i++) begin
      v = rnd128();
      run_block(v, model(v, inv_sel), $sformatf("inverse rnd%0d", i));
    end
    inv_sel = 1'b0;
    v = rnd128();
    run_block(v, model(v, inv_sel), "forward after inverse");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
